programmable_sequence_detector_fsm: RTL and testbench
=====================================================

// Module: programmable_sequence_detector_fsm
// PURPOSE
//  Serial bit-stream sequence detector with a runtime-loadable pattern of 1..MAX_LEN bits.
//  Supports overlapping and non-overlapping match modes, plus input valid qualification.
//  Keeps a saturating match counter.
//  Generalises the fixed-pattern FSM detectors so one block covers any short sync/marker word.
//  Sits between a serial bit source and the control logic that reacts to marker hits.
// PARAMETERS
//  MAX_LEN  8  maximum pattern length in bits (>=2)
//  CNT_W    8  width of match_count
//  LEN_W    $clog2(MAX_LEN+1)  width of cfg_len (derived, not overridden)
// PORTS
//  clk          in   1        clock, all logic on posedge
//  rst          in   1        reset, asynchronous, active-high
//  cfg_valid    in   1        load cfg_pattern/cfg_len/cfg_overlap this cycle
//  cfg_pattern  in   MAX_LEN  pattern; bit [cfg_len-1] is received first, bit [0] last
//  cfg_len      in   LEN_W    pattern length, legal 1..MAX_LEN
//  cfg_overlap  in   1        1: overlapping matches allowed; 0: non-overlapping
//  a_valid      in   1        a is a stream bit this cycle
//  a            in   1        serial stream bit
//  clr_count    in   1        synchronous clear of match_count
//  configured   out  1        a legal pattern is loaded (FSM in RUN)
//  cfg_err      out  1        1-cycle pulse: cfg_valid with illegal cfg_len
//  detected     out  1        1-cycle pulse: match completed by the previous accepted bit
//  match_count  out  CNT_W    number of matches, saturating
// BEHAVIOUR
//  Reset (async, rst=1): state=UNCONFIGURED; configured=0, cfg_err=0, detected=0, match_count=0.
//   Reset also clears hist, seen and the stored pattern/len/overlap. Reset applies immediately, mid-stream too.
//  FSM states: UNCONFIGURED -> RUN on a legal cfg_valid; RUN -> RUN on any legal cfg_valid (reload).
//   Illegal cfg (cfg_len==0 or >MAX_LEN): cfg_err=1 for the next cycle.
//   An illegal cfg leaves state, pattern, hist, seen and count untouched.
//  UNCONFIGURED: a_valid ignored, detected stays 0.
//  Legal cfg load: store pattern/len/overlap; clear hist, seen and match_count.
//   detected=0 in the next cycle.
//  RUN, accepted bit (a_valid=1, cfg_valid=0):
//   hist <= {hist[MAX_LEN-2:0], a} (hist[0] newest).
//   seen <= min(seen+1, MAX_LEN).
//   Match when seen_next >= len and hist_next[len-1:0] == pattern[len-1:0].
//  Match: detected=1 in the cycle after the edge that sampled the final bit (latency 1, registered, Moore-style).
//   On a match, match_count increments at the same edge and saturates at 2^CNT_W-1.
//   Overlap=1: seen unaffected by the match.
//   Overlap=0: seen <= 0 at the match edge, so the next match needs len fresh bits.
//  a_valid=0: no shift, no count change, detected=0. Gaps never break a partial match.
//  Simultaneous events:
//   cfg_valid with a_valid: cfg wins, the bit is discarded.
//   clr_count with a match: count <= 0, but detected still pulses.
//   clr_count with a legal cfg: count <= 0.
//  len=1: every accepted bit equal to pattern[0] matches, in both modes.
//  All outputs are registered. There are no combinational paths from inputs to outputs.
// TESTING (MAX_LEN=8, CNT_W=8 unless stated)
//  T1: cfg 6'b110011, overlap=1; bits 1,1,0,0,1,1,0,0,1,1 one per cycle.
//   Required: detected after bit 6 and bit 10; count=2.
//  T2: same pattern and stream with overlap=0.
//   Required: detected only after bit 6; count=1.
//  T3: cfg 4'b1010, overlap=1, stream 1,0,1,0,1,0 with a_valid low 3 cycles between bits 2 and 3.
//   Required: detected after bits 4 and 6; no pulse during the gap.
//  T4: CNT_W=2, cfg len=1 pattern 1, stream of five 1s.
//   Required: 5 detected pulses; count 1,2,3,3,3.
//   Then clr_count -> count=0.
//  T5: cfg_len=0, then cfg_len=9.
//   Required: cfg_err pulse each time; configured stays 0; later a_valid bits give no detection.
//  T6: mid-match (3 of 4 bits of 1010 received), assert rst asynchronously between edges.
//   Required: outputs 0 immediately, configured=0.
//   After reconfig, the 4th bit alone gives no detection.

Source files
------------

// File: rtl/programmable_sequence_detector_fsm.sv
// -----------------------------------------------------------------------------
// programmable_sequence_detector_fsm
//
// Serial bit-stream sequence detector with a runtime-loadable pattern of
// 1..MAX_LEN bits. Supports overlapping and non-overlapping match modes,
// qualifies stream bits with a_valid, and keeps a saturating match counter.
//
// Ports:
//   clk          clock, all logic on posedge
//   rst          asynchronous active-high reset
//   cfg_valid    load cfg_pattern/cfg_len/cfg_overlap this cycle
//   cfg_pattern  pattern; bit [cfg_len-1] received first, bit [0] last
//   cfg_len      pattern length, legal 1..MAX_LEN
//   cfg_overlap  1: overlapping matches; 0: non-overlapping
//   a_valid      a carries a stream bit this cycle
//   a            serial stream bit
//   clr_count    synchronous clear of match_count
//   configured   a legal pattern is loaded (FSM in RUN)
//   cfg_err      1-cycle pulse after cfg_valid with an illegal cfg_len
//   detected     1-cycle pulse after the edge that accepted a match's last bit
//   match_count  saturating number of matches since last load/clear
// -----------------------------------------------------------------------------
module programmable_sequence_detector_fsm #(
   parameter  int MAX_LEN = 8,
   parameter  int CNT_W   = 8,
   localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_valid,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
   input  logic               a_valid,
   input  logic               a,
   input  logic               clr_count,
   output logic               configured,
   output logic               cfg_err,
   output logic               detected,
   output logic [CNT_W-1:0]   match_count
);

   typedef enum logic {S_UNCFG, S_RUN} state_t;

   state_t             state;
   logic [MAX_LEN-1:0] pat_r;
   logic [LEN_W-1:0]   len_r;
   logic               ovl_r;
   logic [MAX_LEN-1:0] hist;     // hist[0] is the newest accepted bit
   logic [LEN_W-1:0]   seen;     // accepted bits that may take part in a match

   logic               cfg_legal;
   logic [MAX_LEN-1:0] hist_n;
   logic [LEN_W-1:0]   seen_n;
   logic [MAX_LEN-1:0] mask;
   logic               hit;

   always_comb begin
      cfg_legal = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
      hist_n    = {hist[MAX_LEN-2:0], a};
      seen_n    = (seen == LEN_W'(MAX_LEN)) ? seen : seen + 1'b1;
      mask      = '0;
      for (int i = 0; i < MAX_LEN; i++)
         mask[i] = (i < int'(len_r));
      // Only the low len bits of the history are compared; stale bits above
      // the pattern length are ignored.
      hit = (seen_n >= len_r) && (((hist_n ^ pat_r) & mask) == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_UNCFG;
         configured  <= 1'b0;
         cfg_err     <= 1'b0;
         detected    <= 1'b0;
         match_count <= '0;
         pat_r       <= '0;
         len_r       <= '0;
         ovl_r       <= 1'b0;
         hist        <= '0;
         seen        <= '0;
      end else begin
         cfg_err  <= 1'b0;
         detected <= 1'b0;
         if (cfg_valid) begin
            // Configuration has priority; a stream bit in the same cycle is dropped.
            if (cfg_legal) begin
               state       <= S_RUN;
               configured  <= 1'b1;
               pat_r       <= cfg_pattern;
               len_r       <= cfg_len;
               ovl_r       <= cfg_overlap;
               hist        <= '0;
               seen        <= '0;
               match_count <= '0;
            end else begin
               cfg_err <= 1'b1;
            end
         end else if (state == S_RUN && a_valid) begin
            hist <= hist_n;
            if (hit) begin
               detected <= 1'b1;
               seen     <= ovl_r ? seen_n : '0;
               if (match_count != {CNT_W{1'b1}})
                  match_count <= match_count + 1'b1;
            end else begin
               seen <= seen_n;
            end
         end
         // Clear wins over any increment in the same cycle; detected is unaffected.
         if (clr_count)
            match_count <= '0;
      end
   end

endmodule

// File: tb/tb_programmable_sequence_detector_fsm.sv
module tb_programmable_sequence_detector_fsm;

   logic       clk = 1'b0;
   logic       rst;
   logic       cfg_valid;
   logic [7:0] cfg_pattern;
   logic [3:0] cfg_len;
   logic       cfg_overlap;
   logic       a_valid;
   logic       a;
   logic       clr_count;
   logic       configured, cfg_err, detected;
   logic [7:0] match_count;
   logic       configured2, cfg_err2, detected2;
   logic [1:0] match_count2;

   int vectors = 0;
   int miscompares = 0;

   // reference model state
   bit       m_cfgd;
   bit [7:0] m_pat;
   int       m_len;
   bit       m_ovl;
   bit       q[$];      // accepted bits still eligible to form a match
   int       m_cnt;     // unbounded match count since last load/clear
   logic     exp_det, exp_err, exp_cfgd;
   logic [7:0] exp_c8;
   logic [1:0] exp_c2;

   always #5 clk = ~clk;

   programmable_sequence_detector_fsm #(.MAX_LEN(8), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .a_valid(a_valid), .a(a),
      .clr_count(clr_count), .configured(configured), .cfg_err(cfg_err),
      .detected(detected), .match_count(match_count));

   programmable_sequence_detector_fsm #(.MAX_LEN(8), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .a_valid(a_valid), .a(a),
      .clr_count(clr_count), .configured(configured2), .cfg_err(cfg_err2),
      .detected(detected2), .match_count(match_count2));

   task automatic model_reset();
      m_cfgd = 0; m_pat = 0; m_len = 0; m_ovl = 0; q.delete(); m_cnt = 0;
      exp_det = 0; exp_err = 0; exp_cfgd = 0; exp_c8 = 0; exp_c2 = 0;
   endtask

   task automatic idle_inputs();
      cfg_valid = 0; cfg_pattern = 0; cfg_len = 0; cfg_overlap = 0;
      a_valid = 0; a = 0; clr_count = 0;
   endtask

   // Apply one cycle of inputs, advance the model at the edge, return #1 later.
   task automatic cycle(input logic cv, input logic [7:0] p, input logic [3:0] l,
                        input logic ov, input logic av, input logic b, input logic clr);
      bit legal, m;
      cfg_valid = cv; cfg_pattern = p; cfg_len = l; cfg_overlap = ov;
      a_valid = av; a = b; clr_count = clr;
      @(posedge clk);
      legal = (l >= 1) && (l <= 8);
      exp_det = 0;
      exp_err = cv && !legal;
      if (cv) begin
         if (legal) begin
            m_cfgd = 1; m_pat = p; m_len = int'(l); m_ovl = ov; q.delete(); m_cnt = 0;
         end
      end else if (m_cfgd && av) begin
         q.push_back(b);
         m = (q.size() >= m_len);
         for (int k = 0; k < m_len && m; k++)
            if (q[q.size() - 1 - k] != m_pat[k]) m = 0;
         if (m) begin
            exp_det = 1;
            m_cnt++;
            if (!m_ovl) q.delete();
         end
      end
      if (clr) m_cnt = 0;
      exp_cfgd = m_cfgd;
      exp_c8 = (m_cnt > 255) ? 8'd255 : 8'(m_cnt);
      exp_c2 = (m_cnt > 3) ? 2'd3 : 2'(m_cnt);
      #1;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1;
      @(posedge clk);
      #1;
      model_reset();
      rst = 0;
   endtask

   task automatic test_reset();
      do_reset();
      vectors++;
      if ({detected, detected2, cfg_err, cfg_err2, configured, configured2, match_count, match_count2} !== 14'b0) begin
         miscompares++;
         $display("FAIL reset: det=%b/%b err=%b/%b cfgd=%b/%b cnt=%0d/%0d, want all 0",
                  detected, detected2, cfg_err, cfg_err2, configured, configured2, match_count, match_count2);
      end
   endtask

   task automatic test_t1_overlap();
      logic [9:0] s = 10'b1100110011;
      int ndet = 0;
      do_reset();
      cycle(1, 8'b00110011, 4'd6, 1, 0, 0, 0);
      for (int i = 9; i >= 0; i--) begin
         cycle(0, 0, 0, 0, 1, s[i], 0);
         ndet += int'(detected);
         vectors++;
         if ({detected, detected2, cfg_err, configured, match_count, match_count2} !== {exp_det, exp_det, exp_err, exp_cfgd, exp_c8, exp_c2}) begin
            miscompares++;
            $display("FAIL t1_overlap bit%0d: det=%b/%b err=%b cfgd=%b cnt=%0d/%0d, want det=%b err=%b cfgd=%b cnt=%0d/%0d",
                     10 - i, detected, detected2, cfg_err, configured, match_count, match_count2, exp_det, exp_err, exp_cfgd, exp_c8, exp_c2);
         end
      end
      vectors++;
      if (ndet != 2 || match_count !== 8'd2) begin
         miscompares++;
         $display("FAIL t1_total: pulses=%0d count=%0d, want 2 and 2", ndet, match_count);
      end
   endtask

   task automatic test_t2_nonoverlap();
      logic [9:0] s = 10'b1100110011;
      int ndet = 0;
      do_reset();
      cycle(1, 8'b00110011, 4'd6, 0, 0, 0, 0);
      for (int i = 9; i >= 0; i--) begin
         cycle(0, 0, 0, 0, 1, s[i], 0);
         ndet += int'(detected);
         vectors++;
         if ({detected, detected2, cfg_err, configured, match_count, match_count2} !== {exp_det, exp_det, exp_err, exp_cfgd, exp_c8, exp_c2}) begin
            miscompares++;
            $display("FAIL t2_nonoverlap bit%0d: det=%b/%b cnt=%0d/%0d, want det=%b cnt=%0d/%0d",
                     10 - i, detected, detected2, match_count, match_count2, exp_det, exp_c8, exp_c2);
         end
      end
      vectors++;
      if (ndet != 1 || match_count !== 8'd1) begin
         miscompares++;
         $display("FAIL t2_total: pulses=%0d count=%0d, want 1 and 1", ndet, match_count);
      end
   endtask

   task automatic test_t3_gaps();
      logic [5:0] s = 6'b101010;
      int ndet = 0;
      do_reset();
      cycle(1, 8'b00001010, 4'd4, 1, 0, 0, 0);
      for (int i = 5; i >= 0; i--) begin
         if (i == 3)
            for (int g = 0; g < 3; g++) begin
               cycle(0, 0, 0, 0, 0, 1, 0);
               vectors++;
               if (detected !== 1'b0 || exp_det !== 1'b0) begin
                  miscompares++;
                  $display("FAIL t3_gap%0d: det=%b, want 0", g, detected);
               end
            end
         cycle(0, 0, 0, 0, 1, s[i], 0);
         ndet += int'(detected);
         vectors++;
         if ({detected, detected2, match_count, match_count2} !== {exp_det, exp_det, exp_c8, exp_c2}) begin
            miscompares++;
            $display("FAIL t3_gaps bit%0d: det=%b/%b cnt=%0d/%0d, want det=%b cnt=%0d/%0d",
                     6 - i, detected, detected2, match_count, match_count2, exp_det, exp_c8, exp_c2);
         end
      end
      vectors++;
      if (ndet != 2) begin
         miscompares++;
         $display("FAIL t3_total: pulses=%0d, want 2", ndet);
      end
   endtask

   task automatic test_t4_len1_saturate();
      logic [1:0] want [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      do_reset();
      cycle(1, 8'b00000001, 4'd1, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         cycle(0, 0, 0, 0, 1, 1, 0);
         vectors++;
         if ({detected2, match_count2, detected, match_count} !== {1'b1, want[i], 1'b1, 8'(i + 1)}) begin
            miscompares++;
            $display("FAIL t4_sat bit%0d: det=%b cnt2=%0d cnt8=%0d, want det=1 cnt2=%0d cnt8=%0d",
                     i + 1, detected2, match_count2, match_count, want[i], i + 1);
         end
      end
      cycle(0, 0, 0, 0, 0, 0, 1);
      vectors++;
      if ({match_count2, match_count, detected} !== {exp_c2, exp_c8, 1'b0} || exp_c8 !== 8'd0) begin
         miscompares++;
         $display("FAIL t4_clr: cnt2=%0d cnt8=%0d det=%b, want 0 0 0", match_count2, match_count, detected);
      end
   endtask

   task automatic test_t5_illegal_cfg();
      logic [3:0] bad [2] = '{4'd0, 4'd9};
      do_reset();
      for (int i = 0; i < 2; i++) begin
         cycle(1, 8'hFF, bad[i], 1, 0, 0, 0);
         vectors++;
         if ({cfg_err, cfg_err2, configured} !== 3'b110) begin
            miscompares++;
            $display("FAIL t5_err len=%0d: err=%b/%b cfgd=%b, want 1/1 0", bad[i], cfg_err, cfg_err2, configured);
         end
         cycle(0, 0, 0, 0, 0, 0, 0);
         vectors++;
         if (cfg_err !== 1'b0) begin
            miscompares++;
            $display("FAIL t5_err_pulse len=%0d: err=%b, want 0", bad[i], cfg_err);
         end
      end
      for (int i = 0; i < 6; i++) begin
         cycle(0, 0, 0, 0, 1, 1, 0);
         vectors++;
         if ({detected, configured, match_count} !== {exp_det, exp_cfgd, exp_c8} || exp_det !== 1'b0) begin
            miscompares++;
            $display("FAIL t5_nodet%0d: det=%b cfgd=%b cnt=%0d, want 0 0 0", i, detected, configured, match_count);
         end
      end
   endtask

   task automatic test_t6_async_reset();
      do_reset();
      cycle(1, 8'b00001010, 4'd4, 1, 0, 0, 0);
      cycle(0, 0, 0, 0, 1, 1, 0);
      cycle(0, 0, 0, 0, 1, 0, 0);
      cycle(0, 0, 0, 0, 1, 1, 0);
      #2;
      rst = 1;
      #1;
      vectors++;
      if ({detected, cfg_err, configured, match_count, configured2} !== 12'b0) begin
         miscompares++;
         $display("FAIL t6_async: det=%b err=%b cfgd=%b cnt=%0d, want all 0", detected, cfg_err, configured, match_count);
      end
      idle_inputs();
      @(posedge clk);
      #1;
      model_reset();
      rst = 0;
      cycle(1, 8'b00001010, 4'd4, 1, 0, 0, 0);
      cycle(0, 0, 0, 0, 1, 0, 0);
      vectors++;
      if ({detected, configured, match_count} !== {exp_det, exp_cfgd, exp_c8} || exp_det !== 1'b0) begin
         miscompares++;
         $display("FAIL t6_after: det=%b cfgd=%b cnt=%0d, want 0 1 0", detected, configured, match_count);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      cycle(1, 8'b00000011, 4'd2, 1, 0, 0, 0);
      // cfg together with a valid bit: bit discarded, history starts empty
      cycle(0, 0, 0, 0, 1, 1, 0);
      cycle(1, 8'b00000011, 4'd2, 1, 1, 1, 0);
      cycle(0, 0, 0, 0, 1, 1, 0);
      vectors++;
      if ({detected, match_count} !== {exp_det, exp_c8} || exp_det !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_cfgwins: det=%b cnt=%0d, want det=%b cnt=%0d", detected, match_count, exp_det, exp_c8);
      end
      // back-to-back overlapping matches, then clr_count together with a match
      cycle(0, 0, 0, 0, 1, 1, 0);
      cycle(0, 0, 0, 0, 1, 1, 0);
      cycle(0, 0, 0, 0, 1, 1, 1);
      vectors++;
      if ({detected, detected2, match_count, match_count2} !== {exp_det, exp_det, exp_c8, exp_c2} || exp_det !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_clrmatch: det=%b/%b cnt=%0d/%0d, want det=1 cnt=%0d/%0d",
                  detected, detected2, match_count, match_count2, exp_c8, exp_c2);
      end
      cycle(0, 0, 0, 0, 1, 1, 0);
      cycle(1, 8'b00000101, 4'd3, 0, 0, 0, 1);
      vectors++;
      if ({detected, configured, match_count} !== {exp_det, exp_cfgd, exp_c8}) begin
         miscompares++;
         $display("FAIL b2b_clrcfg: det=%b cfgd=%b cnt=%0d, want det=%b cfgd=%b cnt=%0d",
                  detected, configured, match_count, exp_det, exp_cfgd, exp_c8);
      end
   endtask

   task automatic test_random();
      logic cv, ov, av, b, clr;
      logic [7:0] p;
      logic [3:0] l;
      do_reset();
      for (int n = 0; n < 1500; n++) begin
         cv  = ($urandom % 25 == 0) || (n == 0);
         l   = ($urandom % 8 == 0) ? (($urandom % 2 == 0) ? 4'd0 : 4'($urandom_range(9, 15)))
                                   : 4'($urandom_range(1, 5));
         p   = 8'($urandom);
         ov  = 1'($urandom);
         av  = ($urandom % 4 != 0);
         b   = 1'($urandom);
         clr = ($urandom % 40 == 0);
         cycle(cv, p, l, ov, av, b, clr);
         vectors++;
         if ({detected, detected2, cfg_err, cfg_err2, configured, configured2, match_count, match_count2} !==
             {exp_det, exp_det, exp_err, exp_err, exp_cfgd, exp_cfgd, exp_c8, exp_c2}) begin
            miscompares++;
            $display("FAIL random cyc%0d: det=%b/%b err=%b/%b cfgd=%b/%b cnt=%0d/%0d, want det=%b err=%b cfgd=%b cnt=%0d/%0d",
                     n, detected, detected2, cfg_err, cfg_err2, configured, configured2, match_count, match_count2,
                     exp_det, exp_err, exp_cfgd, exp_c8, exp_c2);
         end
      end
   endtask

   initial begin
      rst = 1;
      idle_inputs();
      model_reset();
      test_reset();
      test_t1_overlap();
      test_t2_nonoverlap();
      test_t3_gaps();
      test_t4_len1_saturate();
      test_t5_illegal_cfg();
      test_t6_async_reset();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
